// File: rtl/pkg_rv32_types.sv
// Shared types and constants for the RV32 shared-SRAM controller.
//   arb_mode_e        : arbitration policy selector
//   SRAM_WORD_BYTES   : byte lanes per SRAM word
//   MEM_DEPTH_DEFAULT : default SRAM depth in words
package pkg_rv32_types;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned SRAM_WORD_BYTES   = 4;
    localparam int unsigned MEM_DEPTH_DEFAULT = 16384;

endpackage

// File: rtl/rv32_shared_sram_ctrl_if.sv
// Requester-side bus of the shared SRAM controller.
//   req/req_lock/req_we : per-port request, burst lock, write enable
//   req_be/req_addr/req_wdata : per-port payload
//   gnt       : one-hot combinational grant
//   rsp_valid : one-hot response pulse; rsp_err/rsp_rdata shared
//   busy_port : current lock holder (0 when no lock)
interface rv32_shared_sram_ctrl_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned XLEN    = 32
);
    localparam int unsigned BE_W = pkg_rv32_types::SRAM_WORD_BYTES;
    localparam int unsigned PW   = $clog2(N_PORTS);

    logic [N_PORTS-1:0]           req;
    logic [N_PORTS-1:0]           req_lock;
    logic [N_PORTS-1:0]           req_we;
    logic [N_PORTS-1:0][BE_W-1:0] req_be;
    logic [N_PORTS-1:0][XLEN-1:0] req_addr;
    logic [N_PORTS-1:0][XLEN-1:0] req_wdata;
    logic [N_PORTS-1:0]           gnt;
    logic [N_PORTS-1:0]           rsp_valid;
    logic                         rsp_err;
    logic [XLEN-1:0]              rsp_rdata;
    logic [PW-1:0]                busy_port;

    modport master (
        output req, req_lock, req_we, req_be, req_addr, req_wdata,
        input  gnt, rsp_valid, rsp_err, rsp_rdata, busy_port
    );

    modport slave (
        input  req, req_lock, req_we, req_be, req_addr, req_wdata,
        output gnt, rsp_valid, rsp_err, rsp_rdata, busy_port
    );

endinterface

// File: rtl/rv32_rr_arbiter.sv
// Fixed-priority / round-robin arbiter with bounded burst locking.
//   clk, rst      : clock, synchronous active-high reset
//   req_i         : per-port request
//   req_lock_i    : per-port request to keep the grant next cycle
//   gnt_o         : one-hot grant (combinational)
//   gnt_valid_o   : any grant this cycle
//   gnt_idx_o     : index of the granted port
//   busy_port_o   : registered lock holder index, 0 when unlocked
module rv32_rr_arbiter
    import pkg_rv32_types::*;
#(
    parameter int unsigned N        = 2,
    parameter arb_mode_e   MODE     = ARB_RR,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         req_lock_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic [$clog2(N)-1:0] busy_port_o
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = 8;

    // rr_ptr_q doubles as the lock holder: a lock always belongs to the last grantee
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [IW-1:0] busy_q, busy_d;

    logic          lock_active;
    logic          forced;
    logic          hold;
    logic [N-1:0]  holder_oh;
    logic [N-1:0]  others;
    logic [N-1:0]  cand;
    logic [IW-1:0] idx;
    logic          any;
    int            j;

    // Winner selection and next-state
    always_comb begin
        holder_oh   = '0;
        holder_oh[rr_ptr_q] = 1'b1;
        lock_active = (lock_cnt_q != '0);
        forced      = lock_active && (lock_cnt_q == CW'(MAX_LOCK));
        others      = req_i & ~holder_oh;
        hold        = lock_active && !forced && req_i[rr_ptr_q];
        // Forced release: holder sits out one cycle, but only if someone else wants it
        cand        = (forced && (others != '0)) ? others : req_i;
        idx         = rr_ptr_q;
        any         = 1'b0;
        j           = 0;

        if (hold) begin
            any = 1'b1;
        end else if (MODE == ARB_FIXED) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    any = 1'b1;
                    idx = IW'(i);
                end
            end
        end else begin
            // Scan from farthest to nearest so the port after rr_ptr wins last
            for (int k = int'(N); k >= 1; k--) begin
                j = (int'(rr_ptr_q) + k) % int'(N);
                if (cand[IW'(j)]) begin
                    any = 1'b1;
                    idx = IW'(j);
                end
            end
        end

        if (rst) begin
            any = 1'b0;
        end

        gnt_o = '0;
        if (any) begin
            gnt_o[idx] = 1'b1;
        end

        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = '0;
        if (any) begin
            rr_ptr_d = idx;
            if (req_lock_i[idx]) begin
                lock_cnt_d = hold ? (lock_cnt_q + CW'(1)) : CW'(1);
            end
        end
        busy_d = (lock_cnt_d != '0) ? rr_ptr_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= IW'(N - 1);
            lock_cnt_q <= '0;
            busy_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt_valid_o = any;
    assign gnt_idx_o   = idx;
    assign busy_port_o = busy_q;

endmodule

// File: rtl/rv32_shared_sram_ctrl.sv
// Multi-master controller in front of the unified single-port SRAM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of rv32_shared_sram_ctrl_if (requests in,
//              grant/response/busy_port out)
// One access per cycle; responses are registered one cycle after grant.
module rv32_shared_sram_ctrl
    import pkg_rv32_types::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int unsigned ARB_MODE  = 1,
    parameter int unsigned MAX_LOCK  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rv32_shared_sram_ctrl_if.slave  bus
);
    localparam int unsigned IW   = $clog2(N_PORTS);
    localparam int unsigned AW   = $clog2(MEM_DEPTH);
    localparam int unsigned BE_W = SRAM_WORD_BYTES;
    localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(MEM_DEPTH) * (XLEN+1)'(SRAM_WORD_BYTES);

    logic [N_PORTS-1:0] gnt;
    logic               gnt_valid;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      busy_port;

    rv32_rr_arbiter #(
        .N        (N_PORTS),
        .MODE     ((ARB_MODE == 0) ? ARB_FIXED : ARB_RR),
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.req),
        .req_lock_i  (bus.req_lock),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .busy_port_o (busy_port)
    );

    logic            sel_we;
    logic [BE_W-1:0] sel_be;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic            sel_oor;
    logic [AW-1:0]   sel_widx;

    // Payload of the granted port and its range check
    always_comb begin
        sel_we    = bus.req_we[gnt_idx];
        sel_be    = bus.req_be[gnt_idx];
        sel_addr  = bus.req_addr[gnt_idx];
        sel_wdata = bus.req_wdata[gnt_idx];
        sel_oor   = ({1'b0, sel_addr} >= MEM_BYTES);
        sel_widx  = sel_addr[AW+1:2];
    end

    logic [XLEN-1:0] mem_q [MEM_DEPTH];

    // Byte-lane write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (gnt_valid && sel_we && !sel_oor) begin
            for (int k = 0; k < int'(BE_W); k++) begin
                if (sel_be[k]) begin
                    mem_q[sel_widx][8*k +: 8] <= sel_wdata[8*k +: 8];
                end
            end
        end
    end

    logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;

    // Response next-state: read data only for in-range reads
    always_comb begin
        rsp_valid_d = gnt;
        rsp_err_d   = gnt_valid && sel_oor;
        rsp_rdata_d = '0;
        if (gnt_valid && !sel_we && !sel_oor) begin
            rsp_rdata_d = mem_q[sel_widx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.gnt       = gnt;
    // A response still pending when reset rises is dropped, not delivered
    assign bus.rsp_valid = rsp_valid_q & {N_PORTS{~rst}};
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy_port = busy_port;

endmodule
